// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES encryption request scheduler: scheduler
// FSM state encoding and the default latency of the external AES pipeline.
// ---------------------------------------------------------------------------
package aes_pkg;

    // Clock cycles from aes_enable=1 to the matching aes_out being valid.
    localparam int AES_LATENCY_DEFAULT = 12;

    // Scheduler FSM state encoding.
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/aes_result_fifo.sv
// ---------------------------------------------------------------------------
// aes_result_fifo
// First-word-fall-through result FIFO. The head entry is always presented on
// head_data; pop removes it. Push and pop in the same cycle are lossless at
// every fill level, including empty (pop ignored) and full (write lands in
// the slot being freed).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (pointers and count only)
//   push       write push_data this cycle
//   push_data  entry to store
//   pop        remove the head entry (ignored when empty)
//   head_data  current head entry
//   count      number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module aes_result_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    // When full, a concurrent pop frees the slot the write pointer sits on.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The issuing side's credit accounting must make this unreachable.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
                                  !(push && full && !pop));

endmodule

// File: rtl/aes_enc_scheduler.sv
// ---------------------------------------------------------------------------
// aes_enc_scheduler
// Shares one fixed-latency, non-stallable AES encryption pipeline between two
// requesters. Round-robin arbitration, registered issue into the pipeline, a
// tag shift register that follows each block through the pipeline, and a
// result FIFO that returns ciphertexts in issue order with the originating
// requester id. A credit rule (blocks in flight + FIFO entries < FIFO_DEPTH)
// guarantees every returning block has a FIFO slot. flush stops issue, waits
// for everything to drain and pulses flush_done.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_* / req1_*          valid/ready request channels with data and key
//   aes_in, aes_key          registered block/key into the AES pipeline
//   aes_enable               pipeline slot carries a valid block (1 cycle)
//   aes_out                  pipeline ciphertext, AES_LATENCY after enable
//   rsp_valid/ready/data/id  result channel (first-word-fall-through)
//   flush, flush_done        drain request and single-cycle completion pulse
//
// FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   RUN      | normal operation, grants allowed under the credit rule
//   DRAIN    | no grants; wait for pipeline and FIFO to empty
//   DONE     | flush_done pulse for one cycle, then back to RUN
// ---------------------------------------------------------------------------
module aes_enc_scheduler
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int AES_LATENCY  = AES_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [BLOCK_LENGTH-1:0] req0_data,
    input  logic [BLOCK_LENGTH-1:0] req0_key,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [BLOCK_LENGTH-1:0] req1_data,
    input  logic [BLOCK_LENGTH-1:0] req1_key,
    output logic [BLOCK_LENGTH-1:0] aes_in,
    output logic [BLOCK_LENGTH-1:0] aes_key,
    output logic                    aes_enable,
    input  logic [BLOCK_LENGTH-1:0] aes_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [BLOCK_LENGTH-1:0] rsp_data,
    output logic                    rsp_id,
    input  logic                    flush,
    output logic                    flush_done
);

    localparam int IF_W  = $clog2(AES_LATENCY + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 2;

    state_t                   state;
    state_t                   state_nxt;
    logic                     last_grant;
    logic                     gnt_valid;
    logic                     gnt_id;
    logic                     issue_ok;
    logic                     issue;
    logic                     issue_id;
    logic [AES_LATENCY-1:0]   tag_valid;
    logic [AES_LATENCY-1:0]   tag_id;
    logic                     retire;
    logic [IF_W-1:0]          in_flight;
    logic [CNT_W-1:0]         fifo_count;
    logic [BLOCK_LENGTH:0]    fifo_head;
    logic [OCC_W-1:0]         occupancy;
    logic                     drained;
    logic                     pop;

    // Arbitration: on contention grant the requester not granted last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_grant;
        end else if (req0_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
        end else if (req1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    // The block sitting in the issue register has no tag yet, so it is
    // counted separately from in_flight when checking credit.
    assign occupancy = OCC_W'(in_flight) + OCC_W'(aes_enable) + OCC_W'(fifo_count);
    assign issue_ok  = !rst && (state == ST_RUN) && !flush &&
                       (occupancy < OCC_W'(FIFO_DEPTH));

    assign req0_ready = issue_ok && gnt_valid && !gnt_id;
    assign req1_ready = issue_ok && gnt_valid &&  gnt_id;
    assign issue      = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            aes_enable <= 1'b0;
            aes_in     <= '0;
            aes_key    <= '0;
            issue_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            aes_enable <= issue;
            if (issue) begin
                aes_in     <= gnt_id ? req1_data : req0_data;
                aes_key    <= gnt_id ? req1_key  : req0_key;
                issue_id   <= gnt_id;
                last_grant <= gnt_id;
            end
        end
    end

    // Tags enter from the issue register, so the tail lines up with aes_out
    // exactly AES_LATENCY cycles after aes_enable.
    assign retire = tag_valid[AES_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_id    <= '0;
            in_flight <= '0;
        end else begin
            tag_valid <= {tag_valid[AES_LATENCY-2:0], aes_enable};
            tag_id    <= {tag_id[AES_LATENCY-2:0], issue_id};
            case ({aes_enable, retire})
                2'b10:   in_flight <= in_flight + IF_W'(1);
                2'b01:   in_flight <= in_flight - IF_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    assign drained = (in_flight == '0) && !aes_enable && (fifo_count == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (flush)   state_nxt = ST_DRAIN;
            ST_DRAIN: if (drained) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_RUN;
            default:               state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign flush_done = !rst && (state == ST_DONE);

    assign rsp_valid = !rst && (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_head[BLOCK_LENGTH-1:0];
    assign rsp_id    = fifo_head[BLOCK_LENGTH];

    aes_result_fifo #(
        .WIDTH (BLOCK_LENGTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (retire),
        .push_data ({tag_id[AES_LATENCY-1], aes_out}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_aes_enc_scheduler.sv
module tb_aes_enc_scheduler;

    localparam int BL = 128;
    localparam int L  = 12;
    localparam int D  = 16;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [BL-1:0] req0_data, req0_key, req1_data, req1_key;
    logic [BL-1:0] aes_in, aes_key, aes_out, rsp_data;
    logic          aes_enable, rsp_valid, rsp_ready, rsp_id, flush, flush_done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_pop_c = -1;
    int n0 = 0;
    int n1 = 0;
    int grants[$];
    logic [BL:0] got[$];
    logic [BL-1:0] pipe [L];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_enc_scheduler #(.BLOCK_LENGTH(BL), .AES_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
        .aes_in(aes_in), .aes_key(aes_key), .aes_enable(aes_enable), .aes_out(aes_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .flush(flush), .flush_done(flush_done)
    );

    // Stand-in cipher: the known test vector maps to its real AES result,
    // anything else to a cheap reversible scramble.
    function automatic logic [BL-1:0] cipher(input logic [BL-1:0] d, input logic [BL-1:0] k);
        if (d == PT && k == KEY) return CT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    function automatic logic [BL-1:0] mk_data(input logic id, input int n);
        return {8'hd0, 7'h0, id, 80'h0, 32'(n)};
    endfunction

    function automatic logic [BL-1:0] mk_key(input logic id);
        return id ? 128'hfedc_ba98_7654_3210_0123_4567_89ab_cdef
                  : 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    endfunction

    // Pipeline model: a slot with aes_enable low carries junk.
    always @(posedge clk) begin
        pipe[0] <= aes_enable ? cipher(aes_in, aes_key) : {4{32'hdeadbeef}};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign aes_out = pipe[L-1];

    // Record handshakes mid-cycle, where all signals are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);
            if (rsp_valid && rsp_ready) begin
                got.push_back({rsp_id, rsp_data});
                last_pop_c = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cycle(input bit v0, input bit v1);
        bit a0, a1;
        req0_valid = v0; req0_data = mk_data(1'b0, n0); req0_key = mk_key(1'b0);
        req1_valid = v1; req1_data = mk_data(1'b1, n1); req1_key = mk_key(1'b1);
        #1;
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        tick();
        if (a0) n0++;
        if (a1) n1++;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
        repeat (3) tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        tests++; if (aes_enable !== 1'b0) begin fails++; $display("FAIL reset_aes_enable: got %b expected 0", aes_enable); end
        tests++; if (aes_in !== '0) begin fails++; $display("FAIL reset_aes_in: got %h expected 0", aes_in); end
        tests++; if (aes_key !== '0) begin fails++; $display("FAIL reset_aes_key: got %h expected 0", aes_key); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        tick();
        tests++; if ({rsp_valid, flush_done} !== 2'b00) begin fails++; $display("FAIL post_reset_idle: got %b expected 00", {rsp_valid, flush_done}); end
    endtask

    task automatic test_single_block;
        int first;
        logic [BL-1:0] d;
        logic id;
        first = -1; d = '0; id = 1'bx;
        req0_valid = 1'b1; req0_data = PT; req0_key = KEY;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL single_grant: got %b expected 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        tests++; if ({aes_enable, aes_in, aes_key} !== {1'b1, PT, KEY}) begin fails++; $display("FAIL single_issue: got en=%b in=%h key=%h expected en=1 in=%h key=%h", aes_enable, aes_in, aes_key, PT, KEY); end
        for (int k = 2; k <= 40 && first < 0; k++) begin
            tick();
            if (k == 2) begin
                tests++; if (aes_enable !== 1'b0) begin fails++; $display("FAIL single_enable_width: got %b expected 0", aes_enable); end
            end
            if (rsp_valid) begin first = k; d = rsp_data; id = rsp_id; end
        end
        tests++; if (first !== L + 2) begin fails++; $display("FAIL single_latency: got %0d expected %0d", first, L + 2); end
        tests++; if ({id, d} !== {1'b0, CT}) begin fails++; $display("FAIL single_result: got id=%b data=%h expected id=0 data=%h", id, d, CT); end
        tick();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_popped: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        int b0, b1, nn, eid;
        logic [BL:0] exp;
        b0 = n0; b1 = n1;
        grants.delete(); got.delete();
        rsp_ready = 1'b1;
        repeat (20) issue_cycle(1, 1);
        repeat (20) issue_cycle(0, 0);
        tests++; if (grants.size() !== 20) begin fails++; $display("FAIL b2b_grant_count: got %0d expected 20", grants.size()); end
        for (int i = 0; i < grants.size(); i++) begin
            eid = (i % 2 == 0) ? 1 : 0;
            tests++; if (grants[i] !== eid) begin fails++; $display("FAIL b2b_grant_order[%0d]: got %0d expected %0d", i, grants[i], eid); end
        end
        tests++; if (got.size() !== 20) begin fails++; $display("FAIL b2b_rsp_count: got %0d expected 20", got.size()); end
        for (int i = 0; i < got.size() && i < 20; i++) begin
            eid = (i % 2 == 0) ? 1 : 0;
            nn  = (eid == 1 ? b1 : b0) + i / 2;
            exp = {eid[0], cipher(mk_data(eid[0], nn), mk_key(eid[0]))};
            tests++; if (got[i] !== exp) begin fails++; $display("FAIL b2b_rsp[%0d]: got %h expected %h", i, got[i], exp); end
        end
    endtask

    task automatic test_backpressure;
        int b0, b1, nn, eid, total;
        logic [BL:0] exp;
        b0 = n0; b1 = n1;
        grants.delete(); got.delete();
        rsp_ready = 1'b0;
        repeat (40) issue_cycle(1, 1);
        #1;
        tests++; if (grants.size() !== D) begin fails++; $display("FAIL bp_accepted: got %0d expected %0d", grants.size(), D); end
        tests++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b001) begin fails++; $display("FAIL bp_stalled: got %b expected 001", {req0_ready, req1_ready, rsp_valid}); end
        rsp_ready = 1'b1;
        repeat (10) issue_cycle(1, 1);
        repeat (40) issue_cycle(0, 0);
        total = grants.size();
        tests++; if (total <= D) begin fails++; $display("FAIL bp_resumed: got %0d grants expected more than %0d", total, D); end
        tests++; if (got.size() !== total) begin fails++; $display("FAIL bp_rsp_count: got %0d expected %0d", got.size(), total); end
        for (int i = 0; i < got.size(); i++) begin
            eid = (i % 2 == 0) ? 1 : 0;
            nn  = (eid == 1 ? b1 : b0) + i / 2;
            exp = {eid[0], cipher(mk_data(eid[0], nn), mk_key(eid[0]))};
            tests++; if (got[i] !== exp) begin fails++; $display("FAIL bp_rsp[%0d]: got %h expected %h", i, got[i], exp); end
        end
    endtask

    task automatic test_flush;
        int b0, seen;
        bit leak;
        logic [BL:0] exp;
        b0 = n0; seen = -1; leak = 1'b0;
        grants.delete(); got.delete();
        rsp_ready = 1'b1;
        repeat (5) issue_cycle(1, 0);
        tests++; if (grants.size() !== 5) begin fails++; $display("FAIL flush_issued: got %0d expected 5", grants.size()); end
        flush = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL flush_ready_now: got %b expected 00", {req0_ready, req1_ready}); end
        tick();
        flush = 1'b0;
        for (int k = 0; k < 60 && seen < 0; k++) begin
            if (req0_ready || req1_ready) leak = 1'b1;
            if (flush_done) seen = cyc;
            else tick();
        end
        tests++; if (leak !== 1'b0) begin fails++; $display("FAIL flush_no_grant: got leak=%b expected 0", leak); end
        tests++; if (got.size() !== 5) begin fails++; $display("FAIL flush_rsp_count: got %0d expected 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            exp = {1'b0, cipher(mk_data(1'b0, b0 + i), mk_key(1'b0))};
            tests++; if (got[i] !== exp) begin fails++; $display("FAIL flush_rsp[%0d]: got %h expected %h", i, got[i], exp); end
        end
        tests++; if (seen < 0 || seen !== last_pop_c + 2) begin fails++; $display("FAIL flush_done_timing: got cycle %0d expected %0d", seen, last_pop_c + 2); end
        tick();
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL flush_done_pulse: got %b expected 0", flush_done); end
        tests++; if ({req0_ready, req1_ready} !== 2'b01) begin fails++; $display("FAIL flush_back_to_run: got %b expected 01", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit seen_valid;
        seen_valid = 1'b0;
        grants.delete(); got.delete();
        rsp_ready = 1'b1;
        repeat (8) issue_cycle(1, 1);
        tests++; if (grants.size() !== 8) begin fails++; $display("FAIL rstmid_issued: got %0d expected 8", grants.size()); end
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL rstmid_ready: got %b expected 00", {req0_ready, req1_ready}); end
        tick();
        tests++; if ({rsp_valid, aes_enable} !== 2'b00) begin fails++; $display("FAIL rstmid_outputs: got %b expected 00", {rsp_valid, aes_enable}); end
        tests++; if ({aes_in, aes_key} !== '0) begin fails++; $display("FAIL rstmid_aes_regs: got in=%h key=%h expected 0", aes_in, aes_key); end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (30) begin
            tick();
            if (rsp_valid) seen_valid = 1'b1;
        end
        tests++; if (seen_valid !== 1'b0 || got.size() !== 0) begin fails++; $display("FAIL rstmid_no_rsp: got valid_seen=%b rsp=%0d expected 0 and 0", seen_valid, got.size()); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL rstmid_first_grant: got %b expected 10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
